alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of reservation entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 4: ROB tag width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global ready; low freezes all state except flush (REQ-019).
REQ-006 SHALL have port flush_in  input  1  mispredict flush, synchronous.
REQ-007 SHALL have dispatch ports in_valid(1), in_op(7), in_vi(32), in_qi(TAG_W), in_qi_busy(1), in_vj(32), in_qj(TAG_W), in_qj_busy(1), in_imm(32), in_pc(32), in_rob(TAG_W), all inputs.
REQ-008 SHALL have port full_out  output  1  high when no entry is free.
REQ-009 SHALL have CDB ports cdb_valid(1), cdb_tag(TAG_W), cdb_val(32), all inputs.
REQ-010 SHALL have issue ports alu_op(7), alu_vi(32), alu_vj(32), alu_imm(32), alu_pc(32), alu_rob(TAG_W), all outputs, all registered.

Function
REQ-011 SHALL hold per entry: busy, op, vi, qi, qi_busy, vj, qj, qj_busy, imm, pc, rob.
REQ-012 full_out SHALL be combinational from busy bits only: high iff all DEPTH entries busy.
REQ-013 Insert: when rdy_in & in_valid & !full_out & !flush_in, SHALL write the lowest-index free entry and set busy; in_valid while full_out high SHALL be dropped with no state change.
REQ-014 Insert bypass: if cdb_valid and cdb_tag equals an incoming busy tag in the insert cycle, that operand SHALL be stored as cdb_val with its busy bit cleared.
REQ-015 Wakeup: when rdy_in & cdb_valid, every busy entry with qX_busy and qX==cdb_tag SHALL capture cdb_val into vX and clear qX_busy; both operands may wake in the same cycle.
REQ-016 Ready = busy & !qi_busy & !qj_busy, evaluated on registered state; an entry woken or inserted at edge E is first eligible at edge E+1 (min latency insert->alu_op valid = 2 edges... insert edge N, issue edge N+1).
REQ-017 Issue: each rdy_in-high edge SHALL select the lowest-index ready entry, copy op/vi/vj/imm/pc/rob to alu_* registers and clear its busy; if none ready, alu_op SHALL be 7'd0 (other alu_* don't-care, hold).
REQ-018 Insert and issue SHALL occur in the same edge; a slot freed by issue at edge E SHALL be reusable only from edge E+1 (full_out not bypassed).
REQ-019 flush_in high at an edge SHALL clear all busy bits and alu_op to 0, regardless of rdy_in, and override insert/issue/wakeup in that edge.
REQ-020 rdy_in low (no flush): SHALL not insert, issue, or wake; alu_* outputs SHALL hold previous values.
REQ-021 At most one issue per edge; throughput one op/cycle.
REQ-022 Tag compare SHALL use full TAG_W bits; cdb_valid low SHALL cause no capture.

Reset
REQ-023 On rst_in high, immediately (asynchronously): all busy=0, alu_op=0, alu_vi=alu_vj=alu_imm=alu_pc=0, alu_rob=0; full_out therefore 0.
REQ-024 Reset asserted mid-operation SHALL discard all entries; first insert after release SHALL go to entry 0.
REQ-025 Reset SHALL dominate flush_in, rdy_in, and all dispatch/CDB inputs.

Verification
REQ-026 Insert ADD, vi=5 vj=7, both ready, edge N -> after edge N+1 alu_op=ADD, alu_vi=5, alu_vj=7; after edge N+2 alu_op=0.
REQ-027 Insert op with qi=3 busy; edge later cdb_valid tag=3 val=0x10 -> no issue on wake edge, issue next edge with alu_vi=0x10.
REQ-028 Insert with qj=2 busy while cdb tag=2 val=9 same cycle -> entry ready, issues next edge with alu_vj=9.
REQ-029 Fill 8 independent-but-blocked entries -> full_out=1, 9th in_valid dropped; wake entry 5 -> issues, full_out=0 next cycle, new insert lands in entry 5.
REQ-030 Entries 1 and 4 ready, rdy_in low 3 cycles -> alu_* hold, no issue; rdy_in high -> entry 1 issues then entry 4.
REQ-031 4 busy entries, flush_in pulse with rdy_in=0 -> all busy cleared, alu_op=0; rst_in mid-run -> outputs 0 without clock edge.

Source files
------------

// File: rtl/alu_issue_queue.sv
// ALU reservation station: DEPTH entries with CDB wakeup; issues the lowest-index ready entry to registered alu_* outputs.
// Latency insert->issue is one edge; rdy_in low freezes everything except flush; dispatch is dropped while full_out is high.
module alu_issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [6:0]       in_op,
  input  logic [31:0]      in_vi,
  input  logic [TAG_W-1:0] in_qi,
  input  logic             in_qi_busy,
  input  logic [31:0]      in_vj,
  input  logic [TAG_W-1:0] in_qj,
  input  logic             in_qj_busy,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [TAG_W-1:0] in_rob,
  output logic             full_out,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  output logic [6:0]       alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rob
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             busy;
    logic [6:0]       op;
    logic [31:0]      vi;
    logic [TAG_W-1:0] qi;
    logic             qi_busy;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qj;
    logic             qj_busy;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rob;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           new_ent;
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] ready_vec;
  logic             iss_found;
  logic [IW-1:0]    iss_idx;
  logic [IW-1:0]    free_idx;

  logic [6:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_vi_q, alu_vi_d;
  logic [31:0]      alu_vj_q, alu_vj_d;
  logic [31:0]      alu_imm_q, alu_imm_d;
  logic [31:0]      alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0] alu_rob_q, alu_rob_d;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ~ent_q[i].qi_busy & ~ent_q[i].qj_busy;
    end
  end

  assign full_out = &busy_vec;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        iss_found = 1'b1;
        iss_idx   = IW'(i);
      end
      if (!busy_vec[i]) free_idx = IW'(i);
    end
  end

  // Operands whose producer broadcasts in the insert cycle are captured directly.
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = in_op;
    new_ent.qi      = in_qi;
    new_ent.qj      = in_qj;
    new_ent.imm     = in_imm;
    new_ent.pc      = in_pc;
    new_ent.rob     = in_rob;
    new_ent.vi      = in_vi;
    new_ent.qi_busy = in_qi_busy;
    new_ent.vj      = in_vj;
    new_ent.qj_busy = in_qj_busy;
    if (cdb_valid && in_qi_busy && (cdb_tag == in_qi)) begin
      new_ent.vi      = cdb_val;
      new_ent.qi_busy = 1'b0;
    end
    if (cdb_valid && in_qj_busy && (cdb_tag == in_qj)) begin
      new_ent.vj      = cdb_val;
      new_ent.qj_busy = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    alu_op_d  = alu_op_q;
    alu_vi_d  = alu_vi_q;
    alu_vj_d  = alu_vj_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_rob_d = alu_rob_q;
    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
      alu_op_d = 7'd0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && ent_q[i].busy && ent_q[i].qi_busy && (ent_q[i].qi == cdb_tag)) begin
          ent_d[i].vi      = cdb_val;
          ent_d[i].qi_busy = 1'b0;
        end
        if (cdb_valid && ent_q[i].busy && ent_q[i].qj_busy && (ent_q[i].qj == cdb_tag)) begin
          ent_d[i].vj      = cdb_val;
          ent_d[i].qj_busy = 1'b0;
        end
      end
      if (iss_found) begin
        alu_op_d             = ent_q[iss_idx].op;
        alu_vi_d             = ent_q[iss_idx].vi;
        alu_vj_d             = ent_q[iss_idx].vj;
        alu_imm_d            = ent_q[iss_idx].imm;
        alu_pc_d             = ent_q[iss_idx].pc;
        alu_rob_d            = ent_q[iss_idx].rob;
        ent_d[iss_idx].busy  = 1'b0;
      end else begin
        alu_op_d = 7'd0;
      end
      // Slot choice uses registered busy bits, so a slot issued this edge is not reused until the next.
      if (in_valid && !full_out) ent_d[free_idx] = new_ent;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alu_op_q  <= '0;
      alu_vi_q  <= '0;
      alu_vj_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rob_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      alu_op_q  <= alu_op_d;
      alu_vi_q  <= alu_vi_d;
      alu_vj_q  <= alu_vj_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  assign alu_op  = alu_op_q;
  assign alu_vi  = alu_vi_q;
  assign alu_vj  = alu_vj_q;
  assign alu_imm = alu_imm_q;
  assign alu_pc  = alu_pc_q;
  assign alu_rob = alu_rob_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: each task applies hand-computed vectors and checks inline.
module tb_alu_issue_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        in_valid, in_qi_busy, in_qj_busy;
  logic [6:0]  in_op;
  logic [31:0] in_vi, in_vj, in_imm, in_pc;
  logic [3:0]  in_qi, in_qj, in_rob;
  logic        full_out;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [6:0]  alu_op;
  logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
  logic [3:0]  alu_rob;

  int vecs = 0;
  int errs = 0;

  always #5 clk_in = ~clk_in;

  alu_issue_queue #(.DEPTH(8), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_op(in_op), .in_vi(in_vi), .in_qi(in_qi), .in_qi_busy(in_qi_busy),
    .in_vj(in_vj), .in_qj(in_qj), .in_qj_busy(in_qj_busy), .in_imm(in_imm), .in_pc(in_pc),
    .in_rob(in_rob), .full_out(full_out), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob(alu_rob)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_op = 0; in_vi = 0; in_qi = 0; in_qi_busy = 0;
    in_vj = 0; in_qj = 0; in_qj_busy = 0; in_imm = 0; in_pc = 0; in_rob = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0; flush_in = 0;
  endtask

  task automatic drive_ins(input logic [6:0] op, input logic [31:0] vi, input logic [3:0] qi,
                           input logic qib, input logic [31:0] vj, input logic [3:0] qj,
                           input logic qjb, input logic [3:0] rob);
    in_valid = 1; in_op = op; in_vi = vi; in_qi = qi; in_qi_busy = qib;
    in_vj = vj; in_qj = qj; in_qj_busy = qjb; in_rob = rob;
    in_imm = 32'h1000 + 32'(rob); in_pc = 32'h8000_0000 + 32'(rob) * 4;
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_val = val;
  endtask

  task automatic test_reset;
    idle(); rdy_in = 1; rst_in = 1;
    #2;
    vecs++; if (alu_op !== 7'd0) begin errs++; $display("FAIL reset_op: got %h want 00", alu_op); end
    vecs++; if (alu_vi !== 32'd0 || alu_vj !== 32'd0) begin errs++; $display("FAIL reset_v: got %h %h want 0 0", alu_vi, alu_vj); end
    vecs++; if (alu_imm !== 32'd0 || alu_pc !== 32'd0 || alu_rob !== 4'd0) begin errs++; $display("FAIL reset_misc: got %h %h %h want 0", alu_imm, alu_pc, alu_rob); end
    vecs++; if (full_out !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full_out); end
    tick(); tick();
    rst_in = 0;
    tick();
  endtask

  task automatic test_basic;
    drive_ins(7'h33, 32'd5, 4'd0, 0, 32'd7, 4'd0, 0, 4'd1);
    tick(); idle();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL basic_early: got %h want 00", alu_op); end
    tick();
    vecs++; if (alu_op !== 7'h33) begin errs++; $display("FAIL basic_op: got %h want 33", alu_op); end
    vecs++; if (alu_vi !== 32'd5 || alu_vj !== 32'd7) begin errs++; $display("FAIL basic_v: got %0d %0d want 5 7", alu_vi, alu_vj); end
    vecs++; if (alu_imm !== 32'h1001 || alu_pc !== 32'h8000_0004 || alu_rob !== 4'd1) begin errs++; $display("FAIL basic_misc: got %h %h %h want 1001 80000004 1", alu_imm, alu_pc, alu_rob); end
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL basic_idle: got %h want 00", alu_op); end
  endtask

  task automatic test_wakeup;
    drive_ins(7'h13, 32'd0, 4'd3, 1, 32'd2, 4'd0, 0, 4'd2);
    tick(); idle();
    drive_cdb(4'd3, 32'h99); cdb_valid = 0;   // tag matches but not valid
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL wake_novalid: got %h want 00", alu_op); end
    drive_cdb(4'hB, 32'h88);                  // differs from qi=3 only in the top bit
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL wake_tagmiss: got %h want 00", alu_op); end
    drive_cdb(4'd3, 32'h10);
    tick(); idle();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL wake_edge: got %h want 00", alu_op); end
    tick();
    vecs++; if (alu_op !== 7'h13 || alu_vi !== 32'h10 || alu_vj !== 32'd2) begin errs++; $display("FAIL wake_issue: got %h %h %h want 13 10 2", alu_op, alu_vi, alu_vj); end
    tick();
  endtask

  task automatic test_bypass;
    drive_ins(7'h23, 32'd4, 4'd0, 0, 32'd0, 4'd2, 1, 4'd3);
    drive_cdb(4'd2, 32'd9);
    tick(); idle();
    tick();
    vecs++; if (alu_op !== 7'h23 || alu_vi !== 32'd4 || alu_vj !== 32'd9) begin errs++; $display("FAIL bypass: got %h %0d %0d want 23 4 9", alu_op, alu_vi, alu_vj); end
    tick();
  endtask

  task automatic test_dual_wake;
    drive_ins(7'h2B, 32'd0, 4'd5, 1, 32'd0, 4'd5, 1, 4'd4);
    tick(); idle();
    drive_cdb(4'd5, 32'h77);
    tick(); idle();
    tick();
    vecs++; if (alu_op !== 7'h2B || alu_vi !== 32'h77 || alu_vj !== 32'h77) begin errs++; $display("FAIL dual_wake: got %h %h %h want 2b 77 77", alu_op, alu_vi, alu_vj); end
    tick();
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) begin
      drive_ins(7'h40 + 7'(i), 32'd0, 4'(i), 1, 32'd1, 4'd0, 0, 4'(i));
      tick();
    end
    idle();
    vecs++; if (full_out !== 1'b1) begin errs++; $display("FAIL full_set: got %b want 1", full_out); end
    drive_ins(7'h7F, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0, 4'hF);   // ready op, must be dropped
    tick(); idle();
    vecs++; if (full_out !== 1'b1 || alu_op !== 7'h00) begin errs++; $display("FAIL full_drop: got %b %h want 1 00", full_out, alu_op); end
    drive_cdb(4'd5, 32'h55);
    tick(); idle();
    // entry 5 issues at this edge; a same-edge insert must still see full and drop
    drive_ins(7'h7E, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0, 4'hE);
    tick(); idle();
    vecs++; if (alu_op !== 7'h45 || alu_vi !== 32'h55 || alu_rob !== 4'd5) begin errs++; $display("FAIL full_wake5: got %h %h %h want 45 55 5", alu_op, alu_vi, alu_rob); end
    vecs++; if (full_out !== 1'b0) begin errs++; $display("FAIL full_clear: got %b want 0", full_out); end
    drive_ins(7'h50, 32'hAA, 4'd0, 0, 32'hBB, 4'd0, 0, 4'd9);
    tick(); idle();
    vecs++; if (full_out !== 1'b1 || alu_op !== 7'h00) begin errs++; $display("FAIL full_refill: got %b %h want 1 00", full_out, alu_op); end
    tick();
    vecs++; if (alu_op !== 7'h50 || alu_vi !== 32'hAA || alu_rob !== 4'd9) begin errs++; $display("FAIL full_newissue: got %h %h %h want 50 aa 9", alu_op, alu_vi, alu_rob); end
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL full_nodrop: got %h want 00", alu_op); end
  endtask

  task automatic test_flush;
    // seven blocked entries remain; fill slot 5 with a ready op so alu_op is nonzero before flush
    drive_ins(7'h21, 32'd3, 4'd0, 0, 32'd3, 4'd0, 0, 4'd6);
    tick(); idle();
    vecs++; if (full_out !== 1'b1) begin errs++; $display("FAIL flush_prefull: got %b want 1", full_out); end
    tick();
    vecs++; if (alu_op !== 7'h21) begin errs++; $display("FAIL flush_preop: got %h want 21", alu_op); end
    rdy_in = 0; flush_in = 1;
    drive_ins(7'h66, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0, 4'd7);
    tick(); idle(); rdy_in = 1;
    vecs++; if (alu_op !== 7'h00 || full_out !== 1'b0) begin errs++; $display("FAIL flush_clear: got %h %b want 00 0", alu_op, full_out); end
    for (int t = 0; t < 8; t++) begin
      drive_cdb(4'(t), 32'hF0 + 32'(t));
      tick();
      vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL flush_ghost%0d: got %h want 00", t, alu_op); end
    end
    idle(); tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL flush_ghost_end: got %h want 00", alu_op); end
  endtask

  task automatic test_hold;
    drive_ins(7'h60, 32'd0, 4'd1, 1, 32'd0, 4'd0, 0, 4'd0); tick();
    drive_ins(7'h61, 32'd0, 4'd2, 1, 32'd0, 4'd0, 0, 4'd1); tick();
    drive_ins(7'h62, 32'd0, 4'd1, 1, 32'd0, 4'd0, 0, 4'd2); tick();
    drive_ins(7'h63, 32'd0, 4'd1, 1, 32'd0, 4'd0, 0, 4'd3); tick();
    drive_ins(7'h64, 32'd0, 4'd2, 1, 32'd0, 4'd0, 0, 4'd4); tick();
    drive_ins(7'h35, 32'h35, 4'd0, 0, 32'd0, 4'd0, 0, 4'd5); tick();
    idle();
    drive_cdb(4'd2, 32'h22);
    tick(); idle();
    vecs++; if (alu_op !== 7'h35 || alu_rob !== 4'd5) begin errs++; $display("FAIL hold_pre: got %h %h want 35 5", alu_op, alu_rob); end
    rdy_in = 0;
    drive_cdb(4'd1, 32'h31);   // must be ignored while frozen
    for (int c = 0; c < 3; c++) begin
      tick();
      vecs++; if (alu_op !== 7'h35 || alu_vi !== 32'h35 || alu_rob !== 4'd5) begin errs++; $display("FAIL hold_c%0d: got %h %h %h want 35 35 5", c, alu_op, alu_vi, alu_rob); end
    end
    idle(); rdy_in = 1;
    tick();
    vecs++; if (alu_op !== 7'h61 || alu_vi !== 32'h22 || alu_rob !== 4'd1) begin errs++; $display("FAIL hold_e1: got %h %h %h want 61 22 1", alu_op, alu_vi, alu_rob); end
    tick();
    vecs++; if (alu_op !== 7'h64 || alu_rob !== 4'd4) begin errs++; $display("FAIL hold_e4: got %h %h want 64 4", alu_op, alu_rob); end
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL hold_nowake: got %h want 00", alu_op); end
  endtask

  task automatic test_reset_mid;
    drive_cdb(4'd1, 32'h31);
    tick(); idle();
    tick();
    vecs++; if (alu_op !== 7'h60 || alu_vi !== 32'h31) begin errs++; $display("FAIL rmid_pre: got %h %h want 60 31", alu_op, alu_vi); end
    #2 rst_in = 1;
    #1;
    vecs++; if (alu_op !== 7'h00 || alu_vi !== 32'd0 || alu_rob !== 4'd0 || full_out !== 1'b0) begin errs++; $display("FAIL rmid_async: got %h %h %h %b want 00 0 0 0", alu_op, alu_vi, alu_rob, full_out); end
    #1 rst_in = 0;
    drive_ins(7'h0F, 32'h12, 4'd0, 0, 32'h34, 4'd0, 0, 4'hC);
    tick(); idle();
    tick();
    vecs++; if (alu_op !== 7'h0F || alu_rob !== 4'hC) begin errs++; $display("FAIL rmid_new: got %h %h want 0f c", alu_op, alu_rob); end
    tick();
    vecs++; if (alu_op !== 7'h00) begin errs++; $display("FAIL rmid_discard: got %h want 00", alu_op); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_dual_wake();
    test_full();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
